// File: rtl/cond_unit_if.sv
// Flags/branch interface between the pipeline (master) and the condition unit (slave).
// Carries the ALU flags, the branch request and the registered branch decision.
interface cond_unit_if #(
  parameter int CNTW = 16
);
  logic [3:0]      flags_in;
  logic            setflags;
  logic            zero_in;
  logic            br_req;
  logic [1:0]      br_kind;
  logic [3:0]      cond;
  logic            stall;
  logic            flush;
  logic [3:0]      flags_out;
  logic            br_valid;
  logic            br_taken;
  logic [CNTW-1:0] taken_cnt;

  modport master (
    output flags_in, setflags, zero_in, br_req, br_kind, cond, stall, flush,
    input  flags_out, br_valid, br_taken, taken_cnt
  );

  modport slave (
    input  flags_in, setflags, zero_in, br_req, br_kind, cond, stall, flush,
    output flags_out, br_valid, br_taken, taken_cnt
  );
endinterface

// File: rtl/cond_unit.sv
// LEGv8 condition unit: owns the NZVC register, resolves B.cond/CBZ/CBNZ/B with
// same-cycle flag forwarding, registers the decision and counts taken branches.
module cond_unit #(
  parameter int         CNTW    = 16,
  parameter logic [3:0] FLAGRST = 4'b0100
) (
  input logic        clk,
  input logic        rstn,
  cond_unit_if.slave bus
);

  typedef enum logic [1:0] {
    KIND_BCOND = 2'b00,
    KIND_CBZ   = 2'b01,
    KIND_CBNZ  = 2'b10,
    KIND_B     = 2'b11
  } br_kind_e;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [3:0]      nzvc_q, nzvc_d;
  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [3:0] eff;
  logic       f_n, f_z, f_v, f_c;
  logic       cond_pass;
  logic       branch_taken;

  // A flag-setting op in the same cycle as a B.cond must be seen by that B.cond.
  assign eff = bus.setflags ? bus.flags_in : nzvc_q;
  assign {f_n, f_z, f_v, f_c} = eff;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cond_pass = 1'b1;
    unique case (bus.cond)
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = !f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = !f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = !f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = !f_v;
      4'h8: cond_pass = f_c && !f_z;
      4'h9: cond_pass = !f_c || f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = !f_z && (f_n == f_v);
      4'hD: cond_pass = f_z || (f_n != f_v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b1;
    endcase
  end

  always_comb begin
    branch_taken = 1'b1;
    unique case (br_kind_e'(bus.br_kind))
      KIND_BCOND: branch_taken = cond_pass;
      KIND_CBZ:   branch_taken = bus.zero_in;
      KIND_CBNZ:  branch_taken = !bus.zero_in;
      KIND_B:     branch_taken = 1'b1;
    endcase
  end

  // Flush beats stall for the decision; the flag write is gated by stall alone.
  always_comb begin
    nzvc_d  = nzvc_q;
    valid_d = valid_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;

    if (bus.setflags && !bus.stall) begin
      nzvc_d = bus.flags_in;
    end

    if (bus.flush) begin
      valid_d = 1'b0;
      taken_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.br_req;
      taken_d = bus.br_req && branch_taken;
      if (bus.br_req && branch_taken && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nzvc_q  <= FLAGRST;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      nzvc_q  <= nzvc_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.flags_out = nzvc_q;
  assign bus.br_valid  = valid_q;
  assign bus.br_taken  = taken_q;
  assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed steps plus random traffic, compared
// against a behavioural model of the flags register, branch decision and counter.
module tb_cond_unit;

  localparam int         CNTW    = 4;
  localparam logic [3:0] FLAGRST = 4'b0100;
  localparam int         CNT_MAX = (1 << CNTW) - 1;

  logic clk;
  logic rstn;

  cond_unit_if #(.CNTW(CNTW)) bus ();

  cond_unit #(.CNTW(CNTW), .FLAGRST(FLAGRST)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state
  logic [3:0] m_flags;
  logic       m_valid;
  logic       m_taken;
  int         m_cnt;

  // ARM-style condition evaluation: pick a base test from cond[3:1], invert on
  // cond[0] except for 4'b1111, which is treated as always.
  function automatic logic ref_cond(input logic [3:0] nzvc, input logic [3:0] c);
    logic n, z, v, cf, base;
    n = nzvc[3]; z = nzvc[2]; v = nzvc[1]; cf = nzvc[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c[0] && c != 4'hF) return ~base;
    return base;
  endfunction

  function automatic logic ref_taken(input logic [3:0] nzvc, input logic [1:0] kind,
                                     input logic [3:0] c, input logic zero);
    case (kind)
      2'd0:    return ref_cond(nzvc, c);
      2'd1:    return zero;
      2'd2:    return ~zero;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".flags"}, 16'(bus.flags_out), 16'(m_flags));
    check({tag, ".valid"}, 16'(bus.br_valid),  16'(m_valid));
    check({tag, ".taken"}, 16'(bus.br_taken),  16'(m_taken));
    check({tag, ".cnt"},   16'(bus.taken_cnt), 16'(m_cnt));
  endtask

  // Drive one cycle of inputs (caller is just after a negedge), advance the model,
  // and compare all outputs #1 after the rising edge.
  task automatic step(input string tag, input logic setf, input logic [3:0] flags,
                      input logic zero, input logic req, input logic [1:0] kind,
                      input logic [3:0] c, input logic stall, input logic flush);
    logic [3:0] eff;
    logic       tk;
    bus.setflags = setf;  bus.flags_in = flags; bus.zero_in = zero;
    bus.br_req   = req;   bus.br_kind  = kind;  bus.cond    = c;
    bus.stall    = stall; bus.flush    = flush;
    eff = setf ? flags : m_flags;
    tk  = ref_taken(eff, kind, c, zero);
    @(posedge clk);
    if (setf && !stall) m_flags = flags;
    if (flush) begin
      m_valid = 1'b0;
      m_taken = 1'b0;
    end else if (!stall) begin
      m_valid = req;
      m_taken = req & tk;
      if (req && tk && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_flags = FLAGRST;
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_cnt   = 0;
  endtask

  initial begin
    bus.setflags = 1'b0; bus.flags_in = 4'h0; bus.zero_in = 1'b0;
    bus.br_req   = 1'b0; bus.br_kind  = 2'd0; bus.cond    = 4'h0;
    bus.stall    = 1'b0; bus.flush    = 1'b0;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_all("reset");

    // Forwarded flags: N=1,V=0 makes LT true in the same cycle they are set
    step("fwd_lt", 1'b1, 4'b1000, 1'b0, 1'b1, 2'd0, 4'hB, 1'b0, 1'b0);
    step("idle",   1'b0, 4'h0,    1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    // Every condition code under every flag combination, forwarded
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        step("sweep_fwd", 1'b1, 4'(f), 1'b0, 1'b1, 2'd0, 4'(c), 1'b0, 1'b0);

    // Same sweep through the stored register instead of forwarding
    for (int f = 0; f < 16; f++) begin
      step("load", 1'b1, 4'(f), 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++)
        step("sweep_reg", 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 4'(c), 1'b0, 1'b0);
    end

    step("cbz_z1",  1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 4'h0, 1'b0, 1'b0);
    step("cbz_z0",  1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 4'h0, 1'b0, 1'b0);
    step("cbnz_z1", 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 4'h0, 1'b0, 1'b0);
    step("cbnz_z0", 1'b0, 4'h0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0, 1'b0);
    step("b_uncond",1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0, 1'b0, 1'b0);

    // Stall holds flags and the previous decision; flush kills a taken B
    step("stall_set",   1'b1, 4'b0011, 1'b0, 1'b1, 2'd3, 4'h0, 1'b1, 1'b0);
    step("flush_b",     1'b0, 4'h0,    1'b0, 1'b1, 2'd3, 4'h0, 1'b0, 1'b1);
    step("flush_stall", 1'b1, 4'b1111, 1'b0, 1'b1, 2'd3, 4'h0, 1'b1, 1'b1);
    step("flush_set",   1'b1, 4'b0110, 1'b0, 1'b1, 2'd3, 4'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0));

    // Counter saturation from a fresh reset
    rstn = 1'b0;
    model_reset();
    #1;
    rstn = 1'b1;
    #1;
    check_all("rst2");
    for (int i = 0; i < 20; i++)
      step("sat", 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0, 1'b0, 1'b0);

    // Async reset mid-run clears state before the next edge
    bus.br_req = 1'b1; bus.br_kind = 2'd3;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    @(negedge clk);
    rstn = 1'b1;
    step("post_rst", 1'b0, 4'h0, 1'b0, 1'b0, 2'd3, 4'h0, 1'b0, 1'b0);
    step("post_b",   1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 4'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
